// File: rtl/fifo_stream_pkg.sv
// Shared constants and types for the FIFO read-side stream stage.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package fifo_stream_pkg;

    // Default data word width, matching the async FIFO word width.
    localparam int DEF_WIDTH     = 32;

    // Prefetch buffer depth; the credit logic only supports two entries.
    localparam int DEF_BUF_DEPTH = 2;

    // FIFO RAM read latency in cycles (rd_data valid the cycle after rd_en).
    localparam int RD_LAT        = 1;

    // Buffer occupancy, 0..2.
    typedef logic [1:0] level_t;

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry in-order shift buffer; entry0 is always the oldest word.
// Latency: a written word becomes the head on the next edge when the buffer was empty.
// Backpressure: none internally; the caller must never write into a full buffer without a deq.
module rd_skid_buf
    import fifo_stream_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wr_dat,
    input  logic             i_deq,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_head_dat,
    output level_t           o_level
);

    logic [WIDTH-1:0] r_ent0;
    logic [WIDTH-1:0] r_ent1;
    level_t           r_level;
    logic             w_deq;

    // A deq against an empty buffer is meaningless and is ignored.
    assign w_deq = i_deq && (r_level != 2'd0);

    // Shift/append state update; clear has priority over any write or deq.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ent0  <= '0;
            r_ent1  <= '0;
            r_level <= 2'd0;
        end else if (i_clr) begin
            r_ent0  <= '0;
            r_ent1  <= '0;
            r_level <= 2'd0;
        end else begin
            case (r_level)
                2'd0: begin
                    if (i_wr) begin
                        r_ent0  <= i_wr_dat;
                        r_level <= 2'd1;
                    end
                end
                2'd1: begin
                    if (i_wr && w_deq) begin
                        // incoming word replaces the departing head
                        r_ent0 <= i_wr_dat;
                    end else if (i_wr) begin
                        r_ent1  <= i_wr_dat;
                        r_level <= 2'd2;
                    end else if (w_deq) begin
                        r_level <= 2'd0;
                    end
                end
                default: begin
                    // full: only a deq frees a slot, so a write is accepted only alongside one
                    if (w_deq) begin
                        r_ent0 <= r_ent1;
                        if (i_wr) begin
                            r_ent1 <= i_wr_dat;
                        end else begin
                            r_level <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign o_head_dat = r_ent0;
    assign o_level    = r_level;

endmodule

// File: rtl/fifo_rd_stream.sv
// Pops the async FIFO read side and presents words on a first-word-fall-through valid/ready stream.
// Latency: 2 cycles from rd_empty falling to m_valid; 1 word/cycle sustained with m_ready high.
// Backpressure: issues a pop only while buffered + in-flight words (net of this cycle's deq) are below 2.
module fifo_rd_stream
    import fifo_stream_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int BUF_DEPTH = DEF_BUF_DEPTH
) (
    input  logic             rdclk,
    input  logic             rd_rst_n,
    output logic             fifo_rd_en,
    input  logic             fifo_rd_empty,
    input  logic [WIDTH-1:0] fifo_rd_data,
    input  logic             flush,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [1:0]       buf_level
);

    // Total credits equal the buffer depth (fixed at 2).
    localparam logic [2:0] CREDITS = 3'(BUF_DEPTH);

    logic             r_inflight;
    level_t           w_level;
    logic [WIDTH-1:0] w_head_dat;
    logic             w_deq;
    logic [2:0]       w_used;
    logic             w_wr;

    assign w_deq  = m_valid && m_ready;
    // Words committed to the buffer: held now plus the one returning from the RAM.
    assign w_used = {1'b0, w_level} + {2'b00, r_inflight};

    // Issue when the FIFO has data, no flush, and a slot remains after this cycle's deq.
    // Comparing against CREDITS + deq avoids an underflowing subtraction.
    assign fifo_rd_en = rd_rst_n && !fifo_rd_empty && !flush
                        && (w_used < (CREDITS + {2'b00, w_deq}));

    // Track the single pop whose data arrives on the next cycle (RAM read latency RD_LAT = 1).
    always_ff @(posedge rdclk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= fifo_rd_en;
        end
    end

    // Returning data is dropped when a flush coincides with its arrival.
    assign w_wr = r_inflight && !flush;

    rd_skid_buf #(
        .WIDTH      (WIDTH)
    ) u_buf (
        .i_clk      (rdclk),
        .i_rst_n    (rd_rst_n),
        .i_wr       (w_wr),
        .i_wr_dat   (fifo_rd_data),
        .i_deq      (w_deq),
        .i_clr      (flush),
        .o_head_dat (w_head_dat),
        .o_level    (w_level)
    );

    assign m_valid   = (w_level != 2'd0);
    assign m_data    = w_head_dat;
    assign buf_level = w_level;

endmodule
